// File: rtl/packet_tx.sv
// Ethernet frame transmitter: preamble, SFD, MAC header, 64-byte payload from an
// external dual-port RAM, CRC-32 FCS, then an enforced inter-frame gap.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for eth_tx_start; header fields latched on accept
// PRE    | 7 preamble bytes 8'h55
// SFD    | start-of-frame delimiter 8'hD5
// DST    | 6 destination MAC bytes, MSB first
// SRC    | 6 source MAC bytes, MSB first
// TYPE   | 2 EtherType bytes, MSB first
// PAY    | 64 payload bytes read from RAM
// FCS    | 4 bytes of complemented CRC, LSB first
// IFG    | IFG_CYCLES idle cycles with ctl=00; done pulses on the first
module packet_tx #(
    parameter int IFG_CYCLES = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] ethertype,
    input  logic        eth_tx_start,
    output logic        eth_tx_busy,
    output logic        eth_tx_done,
    output logic [5:0]  eth_tx_addr,
    input  logic [7:0]  eth_tx_rdata,
    output logic [7:0]  data,
    output logic [1:0]  ctl
);

    localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam int CNT_W = (IFG_W > 6) ? IFG_W : 6;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_TYPE, S_PAY, S_FCS, S_IFG
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_dec;
    logic [47:0]        dst_q, src_q;
    logic [15:0]        type_q;
    logic [31:0]        crc_q, crc_d, fcs;
    logic [7:0]         data_q, data_d;
    logic [1:0]         ctl_q, ctl_d, fcs_sel;
    logic               busy_q, busy_d, done_q, done_d;
    logic [5:0]         addr_q, addr_d;
    logic               accept, tc;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        return c;
    endfunction

    assign tc      = (cnt_q == '0);
    assign cnt_dec = cnt_q - 1'b1;
    assign fcs     = ~crc_q;
    assign fcs_sel = 2'd3 - cnt_q[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        data_d  = 8'h00;
        ctl_d   = 2'b00;
        busy_d  = busy_q;
        done_d  = 1'b0;
        addr_d  = 6'd0;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                crc_d = CRC_INIT;
                if (eth_tx_start) begin
                    accept  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_PRE;
                    cnt_d   = CNT_W'(6);
                end
            end
            S_PRE: begin
                data_d = 8'h55;
                ctl_d  = 2'b11;
                cnt_d  = cnt_dec;
                if (tc) begin
                    state_d = S_SFD;
                    cnt_d   = '0;
                end
            end
            S_SFD: begin
                data_d  = 8'hD5;
                ctl_d   = 2'b11;
                state_d = S_DST;
                cnt_d   = CNT_W'(5);
            end
            S_DST: begin
                data_d = dst_q[{cnt_q[2:0], 3'b000} +: 8];
                ctl_d  = 2'b11;
                crc_d  = crc32_byte(crc_q, data_d);
                cnt_d  = cnt_dec;
                if (tc) begin
                    state_d = S_SRC;
                    cnt_d   = CNT_W'(5);
                end
            end
            S_SRC: begin
                data_d = src_q[{cnt_q[2:0], 3'b000} +: 8];
                ctl_d  = 2'b11;
                crc_d  = crc32_byte(crc_q, data_d);
                cnt_d  = cnt_dec;
                if (tc) begin
                    state_d = S_TYPE;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_TYPE: begin
                // RAM address leads the payload by two cycles: one for our
                // address register, one for the RAM read register.
                data_d = type_q[{cnt_q[0], 3'b000} +: 8];
                ctl_d  = 2'b11;
                crc_d  = crc32_byte(crc_q, data_d);
                cnt_d  = cnt_dec;
                addr_d = tc ? 6'd1 : 6'd0;
                if (tc) begin
                    state_d = S_PAY;
                    cnt_d   = CNT_W'(63);
                end
            end
            S_PAY: begin
                data_d = eth_tx_rdata;
                ctl_d  = 2'b11;
                crc_d  = crc32_byte(crc_q, data_d);
                cnt_d  = cnt_dec;
                addr_d = addr_q + 1'b1;
                if (tc) begin
                    state_d = S_FCS;
                    cnt_d   = CNT_W'(3);
                end
            end
            S_FCS: begin
                data_d = fcs[{fcs_sel, 3'b000} +: 8];
                ctl_d  = 2'b11;
                cnt_d  = cnt_dec;
                if (tc) begin
                    state_d = S_IFG;
                    cnt_d   = CNT_W'(IFG_CYCLES - 1);
                end
            end
            S_IFG: begin
                done_d = (cnt_q == CNT_W'(IFG_CYCLES - 1));
                cnt_d  = cnt_dec;
                if (tc) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            crc_q   <= CRC_INIT;
            data_q  <= 8'h00;
            ctl_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= 6'd0;
            dst_q   <= 48'h0;
            src_q   <= 48'h0;
            type_q  <= 16'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            data_q  <= data_d;
            ctl_q   <= ctl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            if (accept) begin
                dst_q  <= dst_mac;
                src_q  <= src_mac;
                type_q <= ethertype;
            end
        end
    end

    assign data        = data_q;
    assign ctl         = ctl_q;
    assign eth_tx_busy = busy_q;
    assign eth_tx_done = done_q;
    assign eth_tx_addr = addr_q;

endmodule

// File: tb/tb_packet_tx.sv
// Self-checking bench for packet_tx: fixed reference frame, header byte table,
// randomized frames against a software frame model, gap/done/reset corner cases.
module tb_packet_tx;

    localparam int IFG = 12;
    localparam int FLEN = 90;

    logic        clk;
    logic        rst_n;
    logic [47:0] dst_mac, src_mac;
    logic [15:0] ethertype;
    logic        eth_tx_start;
    logic        eth_tx_busy, eth_tx_done;
    logic [5:0]  eth_tx_addr;
    logic [7:0]  eth_tx_rdata;
    logic [7:0]  data;
    logic [1:0]  ctl;

    packet_tx #(.IFG_CYCLES(IFG)) dut (
        .clk(clk), .rst_n(rst_n), .dst_mac(dst_mac), .src_mac(src_mac),
        .ethertype(ethertype), .eth_tx_start(eth_tx_start),
        .eth_tx_busy(eth_tx_busy), .eth_tx_done(eth_tx_done),
        .eth_tx_addr(eth_tx_addr), .eth_tx_rdata(eth_tx_rdata),
        .data(data), .ctl(ctl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // payload RAM with one-cycle registered read
    logic [7:0] mem [0:63];
    always @(posedge clk) eth_tx_rdata <= mem[eth_tx_addr];

    typedef struct {
        int         idx;
        logic [7:0] val;
    } vec_t;
    vec_t hdr_tbl [19];

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] cap [0:127];
    int         cap_len, cap_gap;
    int         cap_done, cap_ctl11, cap_bad_idle;
    logic [7:0] exp_fr [0:FLEN-1];
    bit         ok;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
        end
        return r;
    endfunction

    task automatic build_model(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
        int          n;
        logic [31:0] crc;
        n = 0;
        for (int i = 0; i < 7; i++) exp_fr[n++] = 8'h55;
        exp_fr[n++] = 8'hD5;
        for (int i = 5; i >= 0; i--) exp_fr[n++] = d[8*i +: 8];
        for (int i = 5; i >= 0; i--) exp_fr[n++] = s[8*i +: 8];
        exp_fr[n++] = t[15:8];
        exp_fr[n++] = t[7:0];
        for (int k = 0; k < 64; k++) exp_fr[n++] = mem[k];
        crc = 32'hFFFFFFFF;
        for (int i = 8; i < 86; i++) crc = crc_upd(crc, exp_fr[i]);
        crc = ~crc;
        for (int i = 0; i < 4; i++) exp_fr[n++] = crc[8*i +: 8];
    endtask

    // samples the current negedge first, then steps; counts idle cycles before the frame
    task automatic capture(input int budget, output bit seen);
        seen    = 1'b0;
        cap_len = 0;
        cap_gap = 0;
        while (ctl != 2'b11 && budget > 0) begin
            if (eth_tx_done) cap_done++;
            if (data != 8'h00) cap_bad_idle++;
            cap_gap++;
            budget--;
            @(negedge clk);
        end
        if (ctl != 2'b11) return;
        while (ctl == 2'b11 && cap_len < 128) begin
            cap[cap_len++] = data;
            @(negedge clk);
        end
        seen = 1'b1;
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            if (eth_tx_done) cap_done++;
            if (ctl == 2'b11) cap_ctl11++;
            else if (data != 8'h00) cap_bad_idle++;
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string name);
        int bad;
        bad = -1;
        n_vec++;
        if (cap_len == FLEN)
            for (int i = 0; i < FLEN; i++)
                if (bad < 0 && cap[i] !== exp_fr[i]) bad = i;
        if (cap_len != FLEN || bad >= 0) begin
            n_bad++;
            if (bad < 0) bad = 0;
            $display("FAIL %s: length %0d (need %0d), byte %0d got %h need %h",
                     name, cap_len, FLEN, bad, cap[bad], exp_fr[bad]);
        end
    endtask

    task automatic check_residue(input string name);
        logic [31:0] crc;
        crc = 32'hFFFFFFFF;
        for (int i = 8; i < FLEN; i++) crc = crc_upd(crc, cap[i]);
        chk(name, crc, 32'hDEBB20E3);
    endtask

    task automatic pulse_start;
        eth_tx_start = 1'b1;
        @(negedge clk);
        eth_tx_start = 1'b0;
    endtask

    initial begin
        hdr_tbl[0]  = '{0,  8'h55};  hdr_tbl[1]  = '{6,  8'h55};
        hdr_tbl[2]  = '{7,  8'hD5};  hdr_tbl[3]  = '{8,  8'h31};
        hdr_tbl[4]  = '{9,  8'h41};  hdr_tbl[5]  = '{10, 8'h59};
        hdr_tbl[6]  = '{11, 8'h26};  hdr_tbl[7]  = '{12, 8'h53};
        hdr_tbl[8]  = '{13, 8'h58};  hdr_tbl[9]  = '{14, 8'h02};
        hdr_tbl[10] = '{15, 8'h00};  hdr_tbl[11] = '{18, 8'h00};
        hdr_tbl[12] = '{19, 8'h01};  hdr_tbl[13] = '{20, 8'h88};
        hdr_tbl[14] = '{21, 8'hB5};  hdr_tbl[15] = '{22, 8'h00};
        hdr_tbl[16] = '{23, 8'h05};  hdr_tbl[17] = '{24, 8'h0A};
        hdr_tbl[18] = '{85, 8'h3B};

        rst_n = 1'b0;
        eth_tx_start = 1'b0;
        dst_mac = 48'h0;
        src_mac = 48'h0;
        ethertype = 16'h0;
        cap_done = 0;
        cap_ctl11 = 0;
        cap_bad_idle = 0;
        for (int k = 0; k < 64; k++) mem[k] = 8'(k * 5);
        repeat (3) @(negedge clk);
        chk("reset_ctl", ctl, 2'b00);
        chk("reset_data", data, 8'h00);
        chk("reset_busy", eth_tx_busy, 1'b0);
        chk("reset_done", eth_tx_done, 1'b0);
        chk("reset_addr", eth_tx_addr, 6'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // reference frame
        dst_mac = 48'h314159265358;
        src_mac = 48'h020000000001;
        ethertype = 16'h88B5;
        build_model(dst_mac, src_mac, ethertype);
        pulse_start();
        chk("accept_busy", eth_tx_busy, 1'b1);
        chk("accept_ctl", ctl, 2'b00);
        capture(200, ok);
        chk("ref_seen", ok, 1'b1);
        chk("ref_latency", cap_gap, 1);
        chk("ref_len", cap_len, FLEN);
        for (int i = 0; i < 19; i++)
            chk($sformatf("ref_byte%0d", hdr_tbl[i].idx), cap[hdr_tbl[i].idx], hdr_tbl[i].val);
        check_frame("ref_frame");
        check_residue("ref_residue");
        chk("ref_done_pulse", eth_tx_done, 1'b1);
        chk("ref_busy_in_ifg", eth_tx_busy, 1'b1);
        watch(IFG + 4);
        chk("ref_done_count", cap_done, 1);
        chk("ref_busy_after", eth_tx_busy, 1'b0);

        // header change right after accept must not reach the wire
        build_model(dst_mac, src_mac, ethertype);
        pulse_start();
        dst_mac = 48'hFFFFFFFFFFFF;
        capture(200, ok);
        chk("latch_seen", ok, 1'b1);
        check_frame("latch_frame");
        watch(IFG + 2);
        dst_mac = 48'h314159265358;

        // randomized frames, inputs scrambled after accept
        for (int r = 0; r < 5; r++) begin
            dst_mac = {$urandom, $urandom};
            src_mac = {$urandom, $urandom};
            ethertype = 16'($urandom);
            for (int k = 0; k < 64; k++) mem[k] = 8'($urandom);
            build_model(dst_mac, src_mac, ethertype);
            pulse_start();
            dst_mac = {$urandom, $urandom};
            src_mac = {$urandom, $urandom};
            ethertype = 16'($urandom);
            capture(200, ok);
            chk($sformatf("rand%0d_seen", r), ok, 1'b1);
            check_frame($sformatf("rand%0d_frame", r));
            check_residue($sformatf("rand%0d_residue", r));
            watch(IFG + 2);
        end

        // extra start pulses mid-frame are dropped
        build_model(dst_mac, src_mac, ethertype);
        pulse_start();
        fork
            capture(200, ok);
            begin
                repeat (20) @(negedge clk);
                pulse_start();
                repeat (30) @(negedge clk);
                pulse_start();
            end
        join
        chk("ignore_seen", ok, 1'b1);
        check_frame("ignore_frame");
        cap_ctl11 = 0;
        watch(40);
        chk("ignore_no_second", cap_ctl11, 0);

        // start held high: back-to-back frames
        for (int k = 0; k < 64; k++) mem[k] = 8'(k * 5);
        dst_mac = 48'h314159265358;
        src_mac = 48'h020000000001;
        ethertype = 16'h88B5;
        build_model(dst_mac, src_mac, ethertype);
        cap_done = 0;
        eth_tx_start = 1'b1;
        for (int f = 0; f < 3; f++) begin
            capture(200, ok);
            chk($sformatf("b2b%0d_seen", f), ok, 1'b1);
            if (f > 0) chk($sformatf("b2b%0d_gap", f), cap_gap, IFG + 1);
            check_frame($sformatf("b2b%0d_frame", f));
        end
        eth_tx_start = 1'b0;
        cap_ctl11 = 0;
        watch(IFG + 6);
        chk("b2b_no_fourth", cap_ctl11, 0);
        chk("b2b_done_count", cap_done, 3);

        // reset during payload byte 20, with start asserted during reset
        build_model(dst_mac, src_mac, ethertype);
        pulse_start();
        for (int b = 0; b < 10 && ctl != 2'b11; b++) @(negedge clk);
        chk("abort_frame_started", ctl, 2'b11);
        repeat (42) @(negedge clk);
        chk("abort_at_pay20", data, exp_fr[42]);
        rst_n = 1'b0;
        eth_tx_start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        eth_tx_start = 1'b0;
        chk("abort_ctl", ctl, 2'b00);
        chk("abort_busy", eth_tx_busy, 1'b0);
        chk("abort_data", data, 8'h00);
        chk("abort_addr", eth_tx_addr, 6'd0);
        cap_done = 0;
        cap_ctl11 = 0;
        watch(30);
        chk("abort_no_done", cap_done, 0);
        chk("abort_start_ignored", cap_ctl11, 0);
        pulse_start();
        capture(200, ok);
        chk("recover_seen", ok, 1'b1);
        check_frame("recover_frame");
        check_residue("recover_residue");
        watch(IFG + 2);

        chk("idle_data_zero", cap_bad_idle, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
